// File: rtl/uart_tx_sched.sv
// uart_tx_sched: four requesters share one UART transmit line. A round-robin
// arbiter picks one valid requester while idle, then the byte is sent as
// start / 8 data bits LSB first / optional even parity / stop.
module uart_tx_sched #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic        tx_serial,
    output logic        busy,
    output logic [1:0]  cur_id,
    output logic        frame_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_q, par_d;
    logic [1:0]       cur_id_q, cur_id_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;

    logic             grant_vld;
    logic [1:0]       grant_id;
    logic [1:0]       idx;
    logic             baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    // Round-robin pick: scan offsets high to low so the one nearest rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = rr_ptr_q;
        idx       = rr_ptr_q;
        for (int i = 3; i >= 0; i--) begin
            idx = rr_ptr_q + 2'(i);
            if (req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
    end

    // State and datapath registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            cur_id_q  <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            cur_id_q  <= cur_id_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    // Next-state: accept a grant in IDLE, then step through the frame one
    // bit period at a time. The baud counter restarts at every bit boundary.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        cur_id_d  = cur_id_q;
        rr_ptr_d  = rr_ptr_q;

        if (state_q != S_IDLE) begin
            baud_d = baud_end ? '0 : baud_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    shreg_d   = req_data[{grant_id, 3'b000} +: 8];
                    cur_id_d  = grant_id;
                    rr_ptr_d  = grant_id + 2'd1;
                    par_d     = 1'b0;
                    baud_d    = '0;
                    bit_cnt_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (baud_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (baud_end) begin
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    par_d     = par_q ^ shreg_q[0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (baud_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (baud_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state. Ready is held off while reset
    // is applied so no handshake can appear to complete during reset.
    always_comb begin
        busy       = (state_q != S_IDLE);
        frame_done = (state_q == S_STOP) && baud_end;
        cur_id     = cur_id_q;
        req_ready  = '0;
        if ((state_q == S_IDLE) && grant_vld && rst) begin
            req_ready = 4'b0001 << grant_id;
        end
        case (state_q)
            S_START:  tx_serial = 1'b0;
            S_DATA:   tx_serial = shreg_q[0];
            S_PARITY: tx_serial = par_q;
            default:  tx_serial = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed steps plus a randomized phase, checked
// against a frame-level reference (expected line value per cycle computed
// from the byte, and grant order from a round-robin pointer).
module tb_uart_tx_sched;

    localparam int C  = 4;
    localparam int P  = 1;
    localparam int F  = (10 + P) * C;
    localparam int C2 = 2;
    localparam int F2 = 10 * C2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_serial, busy, frame_done;
    logic [1:0]  cur_id;

    logic [3:0]  v2;
    logic [31:0] d2;
    logic [3:0]  ready2;
    logic        tx2, busy2, fd2;
    logic [1:0]  id2;

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;

    always #5 clk = ~clk;

    uart_tx_sched #(.CLKS_PER_BIT(C), .PARITY_EN(P)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_serial(tx_serial), .busy(busy),
        .cur_id(cur_id), .frame_done(frame_done)
    );

    uart_tx_sched #(.CLKS_PER_BIT(C2), .PARITY_EN(0)) dut2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_data(d2),
        .req_ready(ready2), .tx_serial(tx2), .busy(busy2),
        .cur_id(id2), .frame_done(fd2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level on cycle n (1-based) after the transfer edge.
    function automatic logic exp_bit(input logic [7:0] b, input int n, input int cpb, input int par);
        int k;
        k = (n - 1) / cpb;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (par != 0 && k == 9) return ^b;
        return 1'b1;
    endfunction

    function automatic int model_pick(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[(ptr_m + i) % 4]) return (ptr_m + i) % 4;
        end
        return -1;
    endfunction

    // Wait for a grant, compare against the model, then check every cycle of
    // the frame. Optional mid-frame request injection and mid-frame reset.
    task automatic do_frame(input int keep, input logic [3:0] inj, input int inj_at,
                            input int rst_at, output int g, output int waited);
        int e;
        logic [7:0] b;
        g = -1;
        waited = 0;
        #1;
        while (req_ready == 4'b0 && waited < 300) begin
            @(negedge clk); #1;
            waited++;
        end
        e = model_pick(req_valid);
        chk("grant_ready", {28'b0, req_ready}, (e < 0) ? 32'd0 : (32'd1 << e));
        if (e < 0) return;
        g = e;
        b = req_data[8*e +: 8];
        @(posedge clk); #1;
        ptr_m = (e + 1) % 4;
        if (keep != 0) req_data[8*e +: 8] = 8'($urandom);
        else req_valid[e] = 1'b0;
        for (int n = 1; n <= F; n++) begin
            @(negedge clk); #1;
            chk("tx", {31'b0, tx_serial}, {31'b0, exp_bit(b, n, C, P)});
            chk("busy", {31'b0, busy}, 32'd1);
            chk("frame_done", {31'b0, frame_done}, (n == F) ? 32'd1 : 32'd0);
            chk("ready_in_frame", {28'b0, req_ready}, 32'd0);
            chk("cur_id", {30'b0, cur_id}, e);
            if (n == inj_at) begin
                for (int k = 0; k < 4; k++) begin
                    if (inj[k] && !req_valid[k]) req_data[8*k +: 8] = 8'($urandom);
                end
                req_valid = req_valid | inj;
            end
            if (n == rst_at) begin
                rst = 1'b0;
                @(posedge clk); #1;
                rst = 1'b1;
                @(negedge clk); #1;
                chk("rst_tx", {31'b0, tx_serial}, 32'd1);
                chk("rst_busy", {31'b0, busy}, 32'd0);
                chk("rst_fd", {31'b0, frame_done}, 32'd0);
                chk("rst_cur_id", {30'b0, cur_id}, 32'd0);
                ptr_m = 0;
                return;
            end
        end
    endtask

    task automatic frame2(input int k, input logic [7:0] b);
        d2[8*k +: 8] = b;
        v2 = 4'b0001 << k;
        #1;
        chk("d2_ready", {28'b0, ready2}, 32'd1 << k);
        @(posedge clk); #1;
        v2 = 4'b0;
        for (int n = 1; n <= F2; n++) begin
            @(negedge clk); #1;
            chk("d2_tx", {31'b0, tx2}, {31'b0, exp_bit(b, n, C2, 0)});
            chk("d2_busy", {31'b0, busy2}, 32'd1);
            chk("d2_fd", {31'b0, fd2}, (n == F2) ? 32'd1 : 32'd0);
            chk("d2_cur_id", {30'b0, id2}, k);
        end
        @(negedge clk); #1;
        chk("d2_idle_busy", {31'b0, busy2}, 32'd0);
        chk("d2_idle_tx", {31'b0, tx2}, 32'd1);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        ptr_m = 0;
    endtask

    initial begin
        int g, w;
        rst = 1'b0;
        req_valid = '0;
        req_data = '0;
        v2 = '0;
        d2 = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_tx", {31'b0, tx_serial}, 32'd1);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_ready", {28'b0, req_ready}, 32'd0);
        chk("reset_cur_id", {30'b0, cur_id}, 32'd0);
        chk("reset_fd", {31'b0, frame_done}, 32'd0);
        chk("reset_tx2", {31'b0, tx2}, 32'd1);
        rst = 1'b1;

        // Single frame 0xA5 from requester 0.
        req_data[7:0] = 8'hA5;
        req_valid = 4'b0001;
        do_frame(0, 4'b0, 0, 0, g, w);
        chk("single_id", g, 0);
        @(negedge clk); #1;
        chk("single_idle_busy", {31'b0, busy}, 32'd0);
        chk("single_idle_tx", {31'b0, tx_serial}, 32'd1);

        // Odd parity byte then zero byte from requester 2.
        req_data[23:16] = 8'h07;
        req_valid = 4'b0100;
        do_frame(0, 4'b0, 0, 0, g, w);
        chk("par_id", g, 2);
        req_data[23:16] = 8'h00;
        req_valid = 4'b0100;
        do_frame(0, 4'b0, 0, 0, g, w);
        chk("zero_id", g, 2);

        // Round robin from reset with all four held valid.
        pulse_reset();
        req_data = $urandom;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            do_frame(1, 4'b0, 0, 0, g, w);
            chk("rr_order", g, i % 4);
            if (i > 0) chk("rr_gap", w, 1);
        end
        req_valid = 4'b0;

        // Fairness: 3 granted, 0 and 3 raise mid-frame -> 0 then 3.
        req_data[31:24] = 8'($urandom);
        req_valid = 4'b1000;
        do_frame(0, 4'b1001, 10, 0, g, w);
        chk("fair_first", g, 3);
        do_frame(0, 4'b0, 0, 0, g, w);
        chk("fair_second", g, 0);
        do_frame(0, 4'b0, 0, 0, g, w);
        chk("fair_third", g, 3);

        // Valid withdrawn in IDLE before any grant edge.
        @(negedge clk); #1;
        req_valid = 4'b0010;
        #1;
        chk("withdraw_ready", {28'b0, req_ready}, 32'd1 << model_pick(req_valid));
        req_valid = 4'b0;
        @(negedge clk); #1;
        chk("withdraw_busy", {31'b0, busy}, 32'd0);
        chk("withdraw_ready_gone", {28'b0, req_ready}, 32'd0);

        // Randomized traffic with mid-frame arrivals.
        for (int it = 0; it < 10; it++) begin
            logic [3:0] m;
            m = 4'($urandom_range(1, 15));
            for (int k = 0; k < 4; k++) begin
                if (m[k] && !req_valid[k])
                    req_data[8*k +: 8] = (it == 3) ? 8'h00 : (it == 5) ? 8'hFF : 8'($urandom);
            end
            req_valid = req_valid | m;
            do_frame(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     int'($urandom_range(1, F)), 0, g, w);
        end
        for (int it = 0; it < 8 && req_valid != 4'b0; it++) begin
            do_frame(0, 4'b0, 0, 0, g, w);
        end

        // Reset during data bit 3; pointer must return to 0.
        @(negedge clk); #1;
        req_valid = 4'b0001;
        req_data[7:0] = 8'($urandom);
        do_frame(0, 4'b0011, 2, 1 + 4 * C + 1, g, w);
        chk("rstmid_first", g, 0);
        do_frame(0, 4'b0, 0, 0, g, w);
        chk("rstmid_grant0", g, 0);
        do_frame(0, 4'b0, 0, 0, g, w);
        chk("rstmid_grant1", g, 1);

        // No parity, two clocks per bit.
        frame2(1, 8'hFF);
        frame2(3, 8'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
